// File: rtl/sipo_deserializer_if.sv
// rtl/sipo_deserializer_if.sv - serial input and parallel output handshake bundle for sipo_deserializer
interface sipo_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             bit_in;
    logic             bit_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;

    modport master (
        output bit_in,
        output bit_valid,
        output out_ready,
        input  data_out,
        input  data_valid
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        input  out_ready,
        output data_out,
        output data_valid
    );
endinterface

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in parallel-out deserializer with one-word output buffer and overrun flag
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    sipo_deserializer_if.slave bus,
    input  logic          flush,
    input  logic          clr_ovr,
    output logic [CW-1:0] bit_cnt,
    output logic          overrun
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovr_q, ovr_d;

    logic [WIDTH-1:0] shift_next;
    logic             capture;
    logic             complete;
    logic             accept;

    assign shift_next = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], bus.bit_in}
                                         : {bus.bit_in, shift_q[WIDTH-1:1]};
    assign capture    = bus.bit_valid && !flush;
    assign complete   = capture && (cnt_q == CW'(WIDTH - 1));
    assign accept     = (state_q == FULL) && bus.out_ready;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;

        if (flush) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (capture) begin
            if (complete) begin
                shift_d = '0;
                cnt_d   = '0;
            end else begin
                shift_d = shift_next;
                cnt_d   = cnt_q + CW'(1);
            end
        end

        // A completed word only has a home if the buffer is empty or being drained this edge.
        if (complete) begin
            if (state_q == EMPTY || accept) begin
                data_d  = shift_next;
                state_d = FULL;
            end
        end else if (accept) begin
            state_d = EMPTY;
        end

        if (complete && state_q == FULL && !accept) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            shift_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = (state_q == FULL);
    assign bit_cnt        = cnt_q;
    assign overrun        = ovr_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - randomized and directed check of sipo_deserializer in both bit orders against a word-level model
module tb_sipo_deserializer;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bi = 1'b0, bv = 1'b0, fl = 1'b0, ordy = 1'b0, clr = 1'b0;

    logic [CW-1:0] cnt1, cnt0;
    logic          ovr1, ovr0;

    int n_cmp = 0;
    int n_err = 0;

    sipo_deserializer_if #(.WIDTH(W)) if1 ();
    sipo_deserializer_if #(.WIDTH(W)) if0 ();

    assign if1.bit_in    = bi;
    assign if1.bit_valid = bv;
    assign if1.out_ready = ordy;
    assign if0.bit_in    = bi;
    assign if0.bit_valid = bv;
    assign if0.out_ready = ordy;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .bus(if1.slave), .flush(fl), .clr_ovr(clr),
        .bit_cnt(cnt1), .overrun(ovr1)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .bus(if0.slave), .flush(fl), .clr_ovr(clr),
        .bit_cnt(cnt0), .overrun(ovr0)
    );

    always #5 clk = ~clk;

    // Model: the partial word is a list of received bits; words are assembled only on completion.
    bit       bits[$];
    bit [W-1:0] m_data1, m_data0;
    bit       m_valid, m_ovr;

    function automatic bit [W-1:0] assemble(bit msb_first);
        bit [W-1:0] w = '0;
        for (int i = 0; i < W; i++) begin
            if (msb_first) w[W-1-i] = bits[i];
            else           w[i]     = bits[i];
        end
        return w;
    endfunction

    task automatic model_reset();
        bits.delete();
        m_data1 = '0;
        m_data0 = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            bit acc, done, set;
            acc  = m_valid && ordy;
            done = 1'b0;
            set  = 1'b0;
            if (fl) begin
                bits.delete();
            end else if (bv) begin
                bits.push_back(bi);
                if (bits.size() == W) begin
                    done = 1'b1;
                    if (!m_valid || acc) begin
                        m_data1 = assemble(1'b1);
                        m_data0 = assemble(1'b0);
                        m_valid = 1'b1;
                    end else begin
                        set = 1'b1;
                    end
                    bits.delete();
                end
            end
            if (!done && acc) m_valid = 1'b0;
            if (set)      m_ovr = 1'b1;
            else if (clr) m_ovr = 1'b0;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("msb.data_out",   32'(if1.data_out),   32'(m_data1));
            chk("msb.data_valid", 32'(if1.data_valid), 32'(m_valid));
            chk("msb.bit_cnt",    32'(cnt1),           32'(bits.size()));
            chk("msb.overrun",    32'(ovr1),           32'(m_ovr));
            chk("lsb.data_out",   32'(if0.data_out),   32'(m_data0));
            chk("lsb.data_valid", 32'(if0.data_valid), 32'(m_valid));
            chk("lsb.bit_cnt",    32'(cnt0),           32'(bits.size()));
            chk("lsb.overrun",    32'(ovr0),           32'(m_ovr));
        end
    end

    task automatic cyc(logic b_v, logic b_i, logic f, logic r, logic c);
        bv = b_v; bi = b_i; fl = f; ordy = r; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(logic [7:0] w, logic ready_last);
        for (int i = 7; i >= 0; i--) cyc(1'b1, w[i], 1'b0, (i == 0) ? ready_last : 1'b0, 1'b0);
    endtask

    task automatic check_zero(string tag);
        chk({tag, ".data1"}, 32'(if1.data_out), 32'h0);
        chk({tag, ".data0"}, 32'(if0.data_out), 32'h0);
        chk({tag, ".valid"}, 32'({if1.data_valid, if0.data_valid}), 32'h0);
        chk({tag, ".cnt"},   32'({cnt1, cnt0}), 32'h0);
        chk({tag, ".ovr"},   32'({ovr1, ovr0}), 32'h0);
    endtask

    initial begin
        logic [7:0] pat;
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 10100101 consecutively: A5 in both orders
        pat = 8'hA5;
        send_word(pat, 1'b0);
        chk("seq_msb.data", 32'(if1.data_out), 32'hA5);
        chk("seq_lsb.data", 32'(if0.data_out), 32'hA5);
        chk("seq.valid",    32'(if1.data_valid), 32'h1);
        chk("seq.cnt",      32'(cnt1), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("accept.valid", 32'(if1.data_valid), 32'h0);

        // same bits with random gaps; bit_cnt runs 1..7 then 0
        for (int i = 7; i >= 0; i--) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            cyc(1'b1, pat[i], 1'b0, 1'b0, 1'b0);
            chk("gap.cnt", 32'(cnt0), 32'((8 - i) % 8));
        end
        chk("gap_lsb.data", 32'(if0.data_out), 32'hA5);

        // backpressure overrun with 3C dropped
        send_word(8'h3C, 1'b0);
        chk("ovr.data", 32'(if1.data_out), 32'hA5);
        chk("ovr.flag", 32'(ovr1), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr.flag", 32'(ovr1), 32'h0);

        // completion coinciding with acceptance
        send_word(8'h3C, 1'b1);
        chk("swap.data", 32'(if1.data_out), 32'h3C);
        chk("swap.valid", 32'(if1.data_valid), 32'h1);
        chk("swap.ovr", 32'(ovr1), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // asynchronous reset mid-word
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        bv = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_word(8'hFF, 1'b0);
        chk("post_rst.data", 32'(if1.data_out), 32'hFF);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // flush beats a coincident bit
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("flush.cnt", 32'(cnt1), 32'h0);
        chk("flush.valid", 32'(if1.data_valid), 32'h0);
        send_word(8'h5A, 1'b0);
        chk("flush_msb.data", 32'(if1.data_out), 32'h5A);
        chk("flush_lsb.data", 32'(if0.data_out), 32'h5A);

        for (int n = 0; n < 3000; n++) begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom),
                1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 20) == 0));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 Parameter WIDTH, default 8, sets the number of serial bits per output word (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1, selects bit order: 1 means the first received bit lands in data_out[WIDTH-1]; 0 means it lands in data_out[0].
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port bit_in, input, 1 bit: serial data bit, taken from the upstream registered (flip-flop) stage output.
REQ-006 Port bit_valid, input, 1 bit: bit_in is captured on a rising edge only when this is high.
REQ-007 Port flush, input, 1 bit: synchronous discard of the partial word.
REQ-008 Port out_ready, input, 1 bit: the consumer accepts data_out.
REQ-009 Port clr_ovr, input, 1 bit: synchronous clear of overrun.
REQ-010 Port data_out, output, WIDTH bits: the assembled word, registered.
REQ-011 Port data_valid, output, 1 bit: data_out holds an unaccepted word.
REQ-012 Port bit_cnt, output, ceil(log2(WIDTH+1)) bits: the number of bits in the partial word (0..WIDTH-1).
REQ-013 Port overrun, output, 1 bit: sticky flag set when a completed word was dropped.

Function
REQ-014 The shift register shall capture bit_in on each rising edge with bit_valid=1 and flush=0. MSB_FIRST=1 shifts left, inserting at bit 0. MSB_FIRST=0 shifts right, inserting at bit WIDTH-1.
REQ-015 bit_cnt shall increment by 1 per captured bit. On the edge capturing bit WIDTH it shall wrap to 0, never reaching WIDTH.
REQ-016 On the edge capturing bit WIDTH, the word (including that bit) completes. It transfers to data_out on that same edge, subject to REQ-018/019, so data_out and data_valid are visible in the following cycle.
REQ-017 Acceptance occurs on a rising edge where data_valid=1 and out_ready=1. data_valid then falls on that edge unless REQ-019 applies.
REQ-018 Output buffer FSM has two states:
  - EMPTY: data_valid=0. Word completion -> FULL.
  - FULL: data_valid=1. Acceptance with no completion -> EMPTY. Otherwise stay in FULL.
REQ-019 Simultaneous completion and acceptance in FULL shall load the new word, hold data_valid=1, and leave overrun unchanged.
REQ-020 Completion in FULL without acceptance shall:
  - drop the new word;
  - keep data_out unchanged;
  - set overrun=1;
  - reset bit_cnt to 0.
REQ-021 data_out shall remain stable while data_valid=1 and no acceptance has occurred.
REQ-022 flush=1 shall clear the partial word and set bit_cnt=0 on that edge, with no effect on data_out, data_valid or overrun. flush shall take priority over a coincident bit_valid, whose bit is discarded.
REQ-023 overrun, once set, shall stay 1 until clr_ovr=1 on an edge. A set event on the same edge as clr_ovr wins (overrun=1).
REQ-024 bit_valid=0 cycles shall leave the shift register and bit_cnt unchanged; gaps of any length are legal.
REQ-025 out_ready shall be ignored while data_valid=0.

Reset
REQ-026 rst=1 shall immediately, without waiting for clk, force:
  - data_out=0, data_valid=0, bit_cnt=0, overrun=0;
  - shift register=0;
  - FSM=EMPTY.
REQ-027 Reset asserted mid-word shall discard the partial bits. After release, the first captured bit shall count as bit 1 of a new word.
REQ-028 No capture, transfer or flag update shall occur on any edge while rst=1.

Verification
REQ-029 MSB_FIRST=1, WIDTH=8: bits 1,0,1,0,0,1,0,1 on 8 consecutive edges, out_ready=0 -> data_out=0xA5 and data_valid=1 from the cycle after the 8th edge; bit_cnt reads 0.
REQ-030 MSB_FIRST=0, same bit sequence with random bit_valid gaps -> data_out=0xA5 (reversed order 10100101 LSB-first), bit_cnt sequence 1..7 then 0.
REQ-031 Backpressure: 0xA5 held with out_ready=0, then a second word 0x3C completes -> data_out stays 0xA5, overrun=1. clr_ovr pulse -> overrun=0.
REQ-032 0xA5 held; the 8th bit of 0x3C arrives on the same edge as out_ready=1 -> data_out=0x3C, data_valid stays 1, overrun=0.
REQ-033 4 bits captured, then rst pulsed between clock edges -> all outputs 0 immediately. Next 8 bits 0xFF -> data_out=0xFF.
REQ-034 3 bits captured, then flush=1 together with bit_valid=1 -> bit_cnt=0 and data_valid unchanged. Next 8 bits form a clean word.
